// File: rtl/m92_shared_ram.sv
// CPU-side responder for the 4 KB shared RAM: true dual-port bytes, post-reset clear, mailbox flags.
// Optional MCU->CPU mailbox interrupt is built only when SHARED_RAM_CPU_INT_EN is defined.
module m92_shared_ram #(
    parameter int                ADDR_W   = 12,
    parameter logic [ADDR_W-1:0] INT_ADDR = 12'hFFF
`ifdef SHARED_RAM_CPU_INT_EN
    ,
    parameter logic [ADDR_W-1:0] CPU_INT_ADDR = 12'hFFE
`endif
) (
    input  logic              CLK_32M,
    input  logic              reset_n,
    input  logic              cpu_cs,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_din,
    output logic [15:0]       cpu_dout,
    output logic              cpu_rd_valid,
    input  logic              ext_ram_cs,
    input  logic              ext_ram_we,
    input  logic [ADDR_W-1:0] ext_ram_addr,
    input  logic [7:0]        ext_ram_dout,
    output logic [7:0]        ext_ram_din,
    output logic              ext_ram_int,
    output logic              cpu_int,
    output logic              busy
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] clr_cnt;
    logic [7:0]        mem [2**ADDR_W];

    logic cpu_wr, cpu_rd, mcu_wr, mcu_rd, run;
    assign cpu_wr = cpu_cs & cpu_we;
    assign cpu_rd = cpu_cs & ~cpu_we;
    assign mcu_wr = ext_ram_cs & ext_ram_we;
    assign mcu_rd = ext_ram_cs & ~ext_ram_we;
    assign run    = (state == RUN);

    always_ff @(posedge CLK_32M) begin
        if (!reset_n) state <= CLEAR;
        else          state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        busy      = 1'b0;
        case (state)
            CLEAR: begin
                busy = 1'b1;
                if (clr_cnt == '1) state_nxt = RUN;
            end
            RUN:     state_nxt = RUN;
            default: state_nxt = CLEAR;
        endcase
    end

    always_ff @(posedge CLK_32M) begin
        if (!reset_n)           clr_cnt <= '0;
        else if (state == CLEAR) clr_cnt <= clr_cnt + 1'b1;
    end

    // CPU write is issued last so it wins a same-address collision with the MCU.
    always_ff @(posedge CLK_32M) begin
        if (reset_n) begin
            if (!run) begin
                mem[clr_cnt] <= 8'h00;
            end else begin
                if (mcu_wr) mem[ext_ram_addr] <= ext_ram_dout;
                if (cpu_wr) mem[cpu_addr]     <= cpu_din;
            end
        end
    end

    // Reads sample mem before this edge's writes land, giving read-first behaviour.
    always_ff @(posedge CLK_32M) begin
        if (!reset_n) begin
            cpu_dout     <= 16'hFFFF;
            cpu_rd_valid <= 1'b0;
            ext_ram_din  <= 8'h00;
            ext_ram_int  <= 1'b0;
        end else begin
            cpu_rd_valid <= cpu_rd;
            if (cpu_rd) cpu_dout <= run ? {8'hFF, mem[cpu_addr]} : 16'hFFFF;
            if (!run)        ext_ram_din <= 8'h00;
            else if (mcu_rd) ext_ram_din <= mem[ext_ram_addr];
            if (!run)                                ext_ram_int <= 1'b0;
            else if (cpu_wr && cpu_addr == INT_ADDR) ext_ram_int <= 1'b1;
            else if (ext_ram_cs && ext_ram_addr == INT_ADDR) ext_ram_int <= 1'b0;
        end
    end

`ifdef SHARED_RAM_CPU_INT_EN
    always_ff @(posedge CLK_32M) begin
        if (!reset_n || !run)                            cpu_int <= 1'b0;
        else if (mcu_wr && ext_ram_addr == CPU_INT_ADDR) cpu_int <= 1'b1;
        else if (cpu_rd && cpu_addr == CPU_INT_ADDR)     cpu_int <= 1'b0;
    end
`else
    assign cpu_int = 1'b0;
`endif

endmodule

// File: tb/tb_m92_shared_ram.sv
// Randomized bench for m92_shared_ram against a per-edge behavioural model of the shared RAM.
module tb_m92_shared_ram;

    logic        CLK_32M = 1'b0;
    logic        reset_n = 1'b0;
    logic        cpu_cs = 1'b0, cpu_we = 1'b0;
    logic [11:0] cpu_addr = '0;
    logic [7:0]  cpu_din = '0;
    logic [15:0] cpu_dout;
    logic        cpu_rd_valid;
    logic        ext_ram_cs = 1'b0, ext_ram_we = 1'b0;
    logic [11:0] ext_ram_addr = '0;
    logic [7:0]  ext_ram_dout = '0;
    logic [7:0]  ext_ram_din;
    logic        ext_ram_int, cpu_int, busy;

`ifdef SHARED_RAM_CPU_INT_EN
    localparam bit CINT = 1'b1;
`else
    localparam bit CINT = 1'b0;
`endif

    always #16 CLK_32M = ~CLK_32M;

    m92_shared_ram dut (
        .CLK_32M(CLK_32M), .reset_n(reset_n),
        .cpu_cs(cpu_cs), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_din(cpu_din),
        .cpu_dout(cpu_dout), .cpu_rd_valid(cpu_rd_valid),
        .ext_ram_cs(ext_ram_cs), .ext_ram_we(ext_ram_we), .ext_ram_addr(ext_ram_addr),
        .ext_ram_dout(ext_ram_dout), .ext_ram_din(ext_ram_din),
        .ext_ram_int(ext_ram_int), .cpu_int(cpu_int), .busy(busy)
    );

    int n_cmp = 0, n_err = 0;

    task automatic chk(input string tag, input logic [15:0] act, input logic [15:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h want %h at %0t", tag, act, exp, $time);
        end
    endtask

    // Reference model: clear_left counts the clear cycles still owed after reset.
    logic [7:0]  rmem [4096];
    int          clear_left = 0;
    logic [15:0] m_dout;
    logic        m_vld, m_int, m_cint;
    logic [7:0]  m_din;

    task automatic model_edge();
        logic [7:0] c_old, m_old;
        if (!reset_n) begin
            clear_left = 4096;
            m_dout = 16'hFFFF; m_vld = 0; m_din = 0; m_int = 0; m_cint = 0;
        end else if (clear_left > 0) begin
            rmem[4096 - clear_left] = 8'h00;
            clear_left--;
            m_vld = cpu_cs && !cpu_we;
            if (m_vld) m_dout = 16'hFFFF;
            m_din = 0; m_int = 0; m_cint = 0;
        end else begin
            c_old = rmem[cpu_addr];
            m_old = rmem[ext_ram_addr];
            m_vld = cpu_cs && !cpu_we;
            if (m_vld) m_dout = {8'hFF, c_old};
            if (ext_ram_cs && !ext_ram_we) m_din = m_old;
            if (ext_ram_cs && ext_ram_addr == 12'hFFF) m_int = 0;
            if (cpu_cs && cpu_we && cpu_addr == 12'hFFF) m_int = 1;
            if (CINT) begin
                if (cpu_cs && !cpu_we && cpu_addr == 12'hFFE) m_cint = 0;
                if (ext_ram_cs && ext_ram_we && ext_ram_addr == 12'hFFE) m_cint = 1;
            end
            if (ext_ram_cs && ext_ram_we) rmem[ext_ram_addr] = ext_ram_dout;
            if (cpu_cs && cpu_we) rmem[cpu_addr] = cpu_din;
        end
    endtask

    task automatic step();
        @(posedge CLK_32M);
        model_edge();
        #1;
        chk("busy", {15'd0, busy}, {15'd0, clear_left > 0});
        chk("cpu_dout", cpu_dout, m_dout);
        chk("rd_valid", {15'd0, cpu_rd_valid}, {15'd0, m_vld});
        chk("ext_din", {8'd0, ext_ram_din}, {8'd0, m_din});
        chk("ext_int", {15'd0, ext_ram_int}, {15'd0, m_int});
        chk("cpu_int", {15'd0, cpu_int}, {15'd0, m_cint});
    endtask

    task automatic cpu_op(input logic cs, input logic we, input logic [11:0] a, input logic [7:0] d);
        cpu_cs = cs; cpu_we = we; cpu_addr = a; cpu_din = d;
    endtask

    task automatic mcu_op(input logic cs, input logic we, input logic [11:0] a, input logic [7:0] d);
        ext_ram_cs = cs; ext_ram_we = we; ext_ram_addr = a; ext_ram_dout = d;
    endtask

    task automatic idle();
        cpu_op(0, 0, 12'h000, 8'h00);
        mcu_op(0, 0, 12'h000, 8'h00);
    endtask

    function automatic logic [11:0] pick_addr();
        logic [3:0] lo;
        lo = 4'($urandom_range(0, 15));
        case ($urandom_range(0, 5))
            0:       return 12'hFFF;
            1:       return 12'hFFE;
            2:       return 12'h050;
            3:       return {8'h12, lo};
            default: return 12'($urandom);
        endcase
    endfunction

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            cpu_op($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, pick_addr(), 8'($urandom));
            mcu_op($urandom_range(0, 2) != 0, $urandom_range(0, 1) == 1, pick_addr(), 8'($urandom));
            step();
        end
        idle();
    endtask

    task automatic wait_clear();
        int k = 0;
        while (busy === 1'b1 && k < 5000) begin
            step();
            k++;
        end
        chk("clear_done", {15'd0, busy}, 16'd0);
    endtask

    initial begin
        int  n;
        logic rdq;
        idle();
        reset_n = 0;
        step(); step();
        chk("rst_dout", cpu_dout, 16'hFFFF);
        chk("rst_busy", {15'd0, busy}, 16'd1);

        // Clear sequence length, with one CPU read while busy
        reset_n = 1;
        n = (busy === 1'b1) ? 1 : 0;
        while (busy === 1'b1 && n < 5000) begin
            rdq = (n == 10);
            cpu_op(rdq, 0, 12'h123, 8'h00);
            step();
            if (rdq) begin
                chk("clr_rd_vld", {15'd0, cpu_rd_valid}, 16'd1);
                chk("clr_rd_dout", cpu_dout, 16'hFFFF);
            end
            if (busy === 1'b1) n++;
        end
        chk("busy_len", 16'(n), 16'd4096);
        idle();
        mcu_op(1, 0, 12'h000, 8'h00); step(); chk("clr_000", {8'd0, ext_ram_din}, 16'h0000);
        mcu_op(1, 0, 12'hABC, 8'h00); step(); chk("clr_abc", {8'd0, ext_ram_din}, 16'h0000);

        // CPU write / MCU read
        idle(); cpu_op(1, 1, 12'h123, 8'h5A); step();
        idle(); mcu_op(1, 0, 12'h123, 8'h00); step(); chk("mcu_rd_123", {8'd0, ext_ram_din}, 16'h005A);
        idle(); cpu_op(1, 0, 12'h123, 8'h00); step();
        chk("cpu_rd_123", cpu_dout, 16'hFF5A);
        chk("cpu_rd_vld", {15'd0, cpu_rd_valid}, 16'd1);
        idle(); step(); chk("cpu_rd_pulse", {15'd0, cpu_rd_valid}, 16'd0);

        // MCU write held 4 cycles, CPU read
        mcu_op(1, 1, 12'h7E0, 8'hC3);
        repeat (4) step();
        idle(); cpu_op(1, 0, 12'h7E0, 8'h00); step(); chk("cpu_rd_7e0", cpu_dout, 16'hFFC3);

        // Mailbox
        idle(); cpu_op(1, 1, 12'hFFF, 8'h01); step(); chk("int_set", {15'd0, ext_ram_int}, 16'd1);
        idle(); mcu_op(1, 0, 12'hFFF, 8'h00); step();
        chk("int_clr", {15'd0, ext_ram_int}, 16'd0);
        chk("int_data", {8'd0, ext_ram_din}, 16'h0001);
        cpu_op(1, 1, 12'hFFF, 8'h01); step(); chk("int_set_wins", {15'd0, ext_ram_int}, 16'd1);

        // Collision
        idle(); cpu_op(1, 1, 12'h050, 8'h11); mcu_op(1, 1, 12'h050, 8'h22); step();
        idle(); cpu_op(1, 0, 12'h050, 8'h00); mcu_op(1, 0, 12'h050, 8'h00); step();
        chk("coll_cpu", cpu_dout, 16'hFF11);
        chk("coll_mcu", {8'd0, ext_ram_din}, 16'h0011);

        // MCU -> CPU mailbox
        idle(); mcu_op(1, 1, 12'hFFE, 8'h77); step(); chk("cint_set", {15'd0, cpu_int}, {15'd0, CINT});
        idle(); cpu_op(1, 0, 12'hFFE, 8'h00); step();
        chk("cint_clr", {15'd0, cpu_int}, 16'd0);
        chk("cint_data", cpu_dout, 16'hFF77);
        idle();

        rand_cycles(3000);

        // Reset mid-RUN, then mid-CLEAR
        reset_n = 0; step(); reset_n = 1;
        chk("rerun_busy", {15'd0, busy}, 16'd1);
        rand_cycles(200);
        reset_n = 0; step(); reset_n = 1;
        rand_cycles(100);
        wait_clear();
        rand_cycles(2000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/m92_shared_ram.md
Name: m92_shared_ram

Overview:
- CPU-side responder for the 4 KB protection/sample shared RAM; the MCU side is the existing MCU emulator's ext_ram_* bus.
- Provides true dual-port byte storage and a post-reset clear sequence.
- Provides a CPU→MCU mailbox interrupt flag at INT_ADDR (set by CPU write, cleared by MCU access).
- Sits between the V33 address decoder and the MCU emulator, clocked at 32 MHz.

Parameters:
- ADDR_W, 12, byte address width of the RAM (depth 2**ADDR_W).
- INT_ADDR, 12'hFFF, mailbox location whose CPU write raises ext_ram_int.
- CPU_INT_ADDR, 12'hFFE, mailbox location whose MCU write raises cpu_int (optional feature only).

Ports:
- CLK_32M  in  1  sole clock.
- reset_n  in  1  reset, synchronous, active-low.
- cpu_cs  in  1  CPU access strobe, level.
- cpu_we  in  1  write qualifier for cpu_cs.
- cpu_addr  in  12  byte address; RAM sits on the CPU low byte lane.
- cpu_din  in  8  CPU write data.
- cpu_dout  out  16  {8'hFF, byte} read data.
- cpu_rd_valid  out  1  one-cycle pulse, cpu_dout valid.
- ext_ram_cs  in  1  MCU access strobe.
- ext_ram_we  in  1  MCU write qualifier.
- ext_ram_addr  in  12  MCU byte address.
- ext_ram_dout  in  8  MCU write data.
- ext_ram_din  out  8  MCU read data.
- ext_ram_int  out  1  mailbox flag to MCU.
- cpu_int  out  1  mailbox flag to CPU (0 when feature absent).
- busy  out  1  clear sequence running.

Behaviour:
- Reset (reset_n low at a clock edge):
  - Outputs: cpu_dout=16'hFFFF, cpu_rd_valid=0, ext_ram_din=8'h00, ext_ram_int=0, cpu_int=0, busy=1.
  - Clear counter=0; state=CLEAR.
  - RAM contents are not reset directly; the CLEAR state overwrites them.
- State CLEAR:
  - Each cycle writes 8'h00 to RAM[counter], then counter+1.
  - When counter==2**ADDR_W-1 is written: state→RUN, busy=0 the next cycle. Total 4096 cycles with busy=1.
  - CPU writes are dropped. CPU reads return 16'hFFFF with normal rd_valid timing.
  - MCU accesses are dropped; ext_ram_din=8'h00.
  - Flags are held at 0.
- Reset mid-CLEAR or mid-RUN: restarts CLEAR from address 0; flags drop the next cycle.
- State RUN, CPU port:
  - cpu_cs&cpu_we writes cpu_din to RAM[cpu_addr] every cycle asserted (level, idempotent).
  - cpu_cs&!cpu_we: registered read; cpu_dout updates and cpu_rd_valid=1 exactly one cycle later.
  - A read held N cycles gives N pulses.
- State RUN, MCU port:
  - ext_ram_cs&ext_ram_we writes ext_ram_dout.
  - ext_ram_cs&!ext_ram_we: ext_ram_din = RAM[ext_ram_addr] one cycle later, held until the next MCU read.
  - The MCU holds cs for a full 8 MHz period, so 1-cycle latency is always met.
- Collision: both ports write the same address in the same cycle → CPU data wins. Read-during-write on either port returns the old data (read-first).
- ext_ram_int:
  - Set when cpu_cs&cpu_we&cpu_addr==INT_ADDR.
  - Cleared when ext_ram_cs&ext_ram_addr==INT_ADDR, read or write.
  - Set and clear in the same cycle → set wins.
  - Changes are visible one cycle after the causing strobe.
- MCU access to INT_ADDR still performs the normal RAM read/write.
- Address compare uses the full 12 bits; no wrap or aliasing.

Optional Feature:
- Macro SHARED_RAM_CPU_INT_EN.
- When defined:
  - cpu_int is set by ext_ram_cs&ext_ram_we&ext_ram_addr==CPU_INT_ADDR.
  - cpu_int is cleared by cpu_cs&!cpu_we&cpu_addr==CPU_INT_ADDR.
  - Set wins over clear; held 0 during CLEAR.
- When undefined: cpu_int is tied 0, no related logic exists, and CPU_INT_ADDR behaves as ordinary RAM.

Test Plan:
- Reset clear: release reset_n → busy high exactly 4096 cycles; then MCU read 12'h000 and 12'hABC → 8'h00; CPU read during busy → 16'hFFFF with rd_valid 1 cycle after cs.
- CPU write / MCU read: CPU writes 8'h5A to 12'h123 → MCU read of 12'h123 returns 8'h5A one cycle after cs; CPU read returns 16'hFF5A with single rd_valid pulse.
- MCU write / CPU read: MCU writes 8'hC3 to 12'h7E0 (held 4 cycles) → CPU read gives 16'hFFC3.
- Mailbox: CPU writes 8'h01 to 12'hFFF → ext_ram_int=1 next cycle; MCU read 12'hFFF → int=0 next cycle, ext_ram_din=8'h01; CPU write and MCU read of 12'hFFF in same cycle → int stays 1.
- Collision: CPU 8'h11 and MCU 8'h22 write 12'h050 same cycle → subsequent read 8'h11.
- With SHARED_RAM_CPU_INT_EN: MCU writes 12'hFFE → cpu_int=1; CPU read 12'hFFE → cpu_int=0. Without the macro: cpu_int stays 0 throughout.
